wash_stage_timer: RTL and testbench
===================================

// Module: wash_stage_timer
// PURPOSE
//  Downstream companion of the car-wash sequencer FSM. Consumes the FSM's 10-bit one-hot stage vector.
//  Times each stage in seconds and returns a one-cycle stage_done pulse that the FSM uses to advance.
//  Drives HEX3..HEX0 with the stage number and the seconds remaining. Sits between the FSM and the board displays.
// PARAMETERS
//  TICK_DIV  50_000_000  CLOCK_50 cycles per 1 s tick (benches use 4)
//  PRE_W     26          prescaler width, must hold TICK_DIV-1
// PORTS
//  CLOCK_50    in   1   system clock, all logic on rising edge
//  RST_n       in   1   asynchronous active-low reset
//  state       in   10  one-hot stage: [9]Idle [8]Soak [7]Soap [6]Brush [5]Blast [4]DWash [3]Dry [2]Wax [1]TireC [0]End
//  speed_sel   in   2   00 standard, 01 fast, 10 slow, 11 = standard
//  hold        in   1   door open: freeze countdown and blink display
//  stage_done  out  1   1-cycle pulse when the current stage's time expires
//  remaining   out  8   seconds left in current stage
//  HEX0..HEX3  out  7   active-low 7-seg {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (async, RST_n=0):
//   - remaining=0, stage_done=0, prescaler=0, blink counter=0, blink phase=on.
//   - state_q=Idle, so the display shows HEX3="0", HEX2 blank, HEX1/HEX0="00".
//  Base durations (s): Soak5 Soap4 Brush6 Blast3 DWash6 Dry5 Wax4 TireC3 End2. Idle=0.
//   - fast: base>>1, minimum 1.
//   - slow: base+(base>>1).
//   - speed_sel is sampled only at load; changing it mid-stage has no effect until the next stage.
//  Stage change (state!=state_q, registered compare):
//   - on the next edge: remaining<=duration, prescaler<=0, stage_done=0.
//   - a reload takes priority over a simultaneous tick.
//  Invalid state (zero bits set or >1 bit set): treated as Idle.
//   - remaining=0, no pulses, HEX3..HEX0 = "----" (7'b0111111).
//  Tick:
//   - prescaler counts 0..TICK_DIV-1 and wraps; sec_tick is asserted on the wrap cycle.
//   - the prescaler does not run in Idle or when remaining=0.
//  Countdown:
//   - on sec_tick with hold=0 and remaining>0: remaining<=remaining-1.
//   - if that is 1->0: stage_done=1 for exactly that cycle (registered, coincident with remaining becoming 0).
//   - remaining=0 holds, with no further pulses until the next stage change.
//   - the FSM moving on in response to stage_done is a normal stage change.
//  Hold:
//   - prescaler and remaining are frozen; no stage_done while hold=1.
//   - a separate blink counter toggles the blink phase every TICK_DIV/2 cycles.
//   - off-phase: all HEX = 7'b1111111. On release, the display returns to steady and counting resumes from the frozen prescaler value.
//   - a stage change during hold still reloads remaining, but the countdown stays frozen.
//  Display (combinational decode of registered values, decimal digits 0-9):
//   - HEX3 = stage index (Idle0, Soak1 .. End9).
//   - HEX2 = blank.
//   - HEX1 = remaining/10, HEX0 = remaining%10.
//  Latency: state change -> remaining/HEX update in 2 cycles (compare register + load).
// TESTING
//  Use TICK_DIV=4.
//  T1 Reset: RST_n=0 asserted mid-count -> immediately remaining=0, stage_done=0, HEX3=7'b1000000, HEX1=HEX0=7'b1000000.
//  T2 Idle->Soak, speed_sel=00:
//   - remaining=5 within 2 cycles, HEX3 shows "1".
//   - decrements every 4 cycles.
//   - single stage_done pulse on the 5th tick; remaining stays 0 with no further pulse.
//  T3 Speed table:
//   - Brush fast -> 3; Blast fast -> 1; Brush slow -> 9; End slow -> 3; speed_sel=11 on Dry -> 5.
//   - speed_sel changed mid-Soak -> current count unaffected.
//  T4 Hold:
//   - hold=1 at remaining=3 for 20 cycles -> remaining stays 3, HEX blank/on alternating every 2 cycles, no stage_done.
//   - after release, the next tick gives 2.
//  T5 Collision: stage change on the same cycle as sec_tick -> remaining reloads to the new duration; no decrement and no stage_done.
//  T6 Invalid input: state=10'b0000000000 and 10'b0110000000 -> HEX "----", remaining=0, no stage_done for 40 cycles.

Source files
------------

// File: rtl/wash_stage_timer.sv
`default_nettype none
// ============================================================================
// Module   : wash_stage_timer
// Purpose  : Times car-wash stages, pulses stage_done on expiry and drives
//            HEX3..HEX0 with the stage number and seconds remaining.
// Revision : 1.0  initial release
// ============================================================================
module wash_stage_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic        CLOCK_50,
    input  logic        RST_n,
    input  logic [9:0]  state,
    input  logic [1:0]  speed_sel,
    input  logic        hold,
    output logic        stage_done,
    output logic [7:0]  remaining,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam logic [9:0]       c_ST_IDLE   = 10'b10_0000_0000;
    localparam int               c_BLINK_DIV = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
    localparam logic [PRE_W-1:0] c_PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] c_BLINK_MAX = PRE_W'(c_BLINK_DIV - 1);

    localparam logic [1:0]       c_SPD_FAST  = 2'b01;
    localparam logic [1:0]       c_SPD_SLOW  = 2'b10;

    localparam logic [6:0]       c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       c_SEG_DASH  = 7'b0111111;

    logic [9:0]       r_state_q;
    logic [9:0]       r_stage;
    logic [7:0]       r_rem;
    logic             r_done;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] r_blink_cnt;
    logic             r_blink_on;

    logic             w_change;
    logic             w_valid;
    logic [3:0]       w_idx;
    logic             w_run;
    logic             w_tick;
    logic [7:0]       w_load_val;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;

    // Stage index of a one-hot vector; anything not exactly one-hot maps to Idle (0).
    function automatic logic [3:0] f_index(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        if ((v != 10'd0) && ((v & (v - 10'd1)) == 10'd0)) begin
            for (int i = 0; i < 10; i++) begin
                if (v[i]) begin
                    idx = 4'(9 - i);
                end
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] f_base(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = 8'd5;
            4'd2:    b = 8'd4;
            4'd3:    b = 8'd6;
            4'd4:    b = 8'd3;
            4'd5:    b = 8'd6;
            4'd6:    b = 8'd5;
            4'd7:    b = 8'd4;
            4'd8:    b = 8'd3;
            4'd9:    b = 8'd2;
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] f_duration(input logic [3:0] idx, input logic [1:0] spd);
        logic [7:0] b;
        logic [7:0] d;
        b = f_base(idx);
        case (spd)
            c_SPD_FAST: d = (b == 8'd0) ? 8'd0 : (((b >> 1) == 8'd0) ? 8'd1 : (b >> 1));
            c_SPD_SLOW: d = b + (b >> 1);
            default:    d = b;
        endcase
        return d;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = c_SEG_BLANK;
        endcase
        return s;
    endfunction

    assign w_change   = (r_state_q != r_stage);
    assign w_valid    = (r_stage != 10'd0) && ((r_stage & (r_stage - 10'd1)) == 10'd0);
    assign w_idx      = f_index(r_stage);
    assign w_run      = w_valid && (w_idx != 4'd0) && (r_rem != 8'd0) && !hold;
    assign w_tick     = w_run && (r_pre == c_PRE_MAX);
    assign w_load_val = f_duration(f_index(r_state_q), speed_sel);

    // A reload always wins over a coincident tick, so no decrement or pulse on a stage change.
    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) begin
            r_state_q <= c_ST_IDLE;
            r_stage   <= c_ST_IDLE;
            r_rem     <= 8'd0;
            r_done    <= 1'b0;
            r_pre     <= '0;
        end else begin
            r_state_q <= state;
            r_done    <= 1'b0;
            if (w_change) begin
                r_stage <= r_state_q;
                r_rem   <= w_load_val;
                r_pre   <= '0;
            end else if (w_run) begin
                if (w_tick) begin
                    r_pre <= '0;
                    r_rem <= r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    end

    // Blink phase restarts "on" whenever hold is released.
    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (hold) begin
            if (r_blink_cnt == c_BLINK_MAX) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end
    end

    assign w_tens = 4'(r_rem / 8'd10);
    assign w_ones = 4'(r_rem % 8'd10);

    always_comb begin
        HEX0 = c_SEG_BLANK;
        HEX1 = c_SEG_BLANK;
        HEX2 = c_SEG_BLANK;
        HEX3 = c_SEG_BLANK;
        if (r_blink_on) begin
            if (!w_valid) begin
                HEX0 = c_SEG_DASH;
                HEX1 = c_SEG_DASH;
                HEX2 = c_SEG_DASH;
                HEX3 = c_SEG_DASH;
            end else begin
                HEX3 = f_seg(w_idx);
                HEX1 = f_seg(w_tens);
                HEX0 = f_seg(w_ones);
            end
        end
    end

    assign stage_done = r_done;
    assign remaining  = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_wash_stage_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_stage_timer
// Purpose  : Randomised and directed self-checking bench for wash_stage_timer.
// Revision : 1.0  initial release
// ============================================================================
module tb_wash_stage_timer;

    localparam int TD = 4;
    localparam int BL = (TD / 2 > 0) ? TD / 2 : 1;

    localparam logic [9:0] IDLE  = 10'b1000000000;
    localparam logic [9:0] SOAK  = 10'b0100000000;
    localparam logic [9:0] SOAP  = 10'b0010000000;
    localparam logic [9:0] BRUSH = 10'b0001000000;
    localparam logic [9:0] BLAST = 10'b0000100000;
    localparam logic [9:0] DRY   = 10'b0000001000;
    localparam logic [9:0] ENDST = 10'b0000000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] state;
    logic [1:0] speed;
    logic       hold;
    logic       stage_done;
    logic [7:0] remaining;
    logic [6:0] hex0, hex1, hex2, hex3;

    wash_stage_timer #(.TICK_DIV(TD), .PRE_W(4)) dut (
        .CLOCK_50  (clk),
        .RST_n     (rst_n),
        .state     (state),
        .speed_sel (speed),
        .hold      (hold),
        .stage_done(stage_done),
        .remaining (remaining),
        .HEX0      (hex0),
        .HEX1      (hex1),
        .HEX2      (hex2),
        .HEX3      (hex3)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    int base_s [10] = '{0, 5, 4, 6, 3, 6, 5, 4, 3, 2};
    logic [6:0] seg_t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model state: seconds left, cycles into current second, pending pulse, blink bookkeeping.
    logic [9:0] m_inq, m_stage;
    int m_rem, m_pre, m_done, m_bcnt, m_phase;

    function automatic int idx_of(input logic [9:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 10; i++) if (v[i]) return 9 - i;
        return -1;
    endfunction

    function automatic int dur(input int idx, input logic [1:0] sp);
        int b;
        if (idx <= 0) return 0;
        b = base_s[idx];
        if (sp == 2'b01) return (b / 2 < 1) ? 1 : b / 2;
        if (sp == 2'b10) return b + b / 2;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inq = IDLE; m_stage = IDLE; m_rem = 0; m_pre = 0; m_done = 0;
            m_bcnt = 0; m_phase = 1;
        end else begin
            logic [9:0] prev_in;
            bit running;
            prev_in = m_inq;
            running = (idx_of(m_stage) > 0) && (m_rem > 0) && !hold;
            m_done  = 0;
            if (prev_in != m_stage) begin
                m_stage = prev_in;
                m_rem   = dur(idx_of(prev_in), speed);
                m_pre   = 0;
            end else if (running) begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_done = 1;
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            m_inq = state;
            if (hold) begin
                if (m_bcnt == BL - 1) begin m_bcnt = 0; m_phase = 1 - m_phase; end
                else m_bcnt = m_bcnt + 1;
            end else begin
                m_bcnt = 0; m_phase = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            int e3, e2, e1, e0, ix;
            ix = idx_of(m_stage);
            if (m_phase == 0) begin
                e3 = 7'h7f; e2 = 7'h7f; e1 = 7'h7f; e0 = 7'h7f;
            end else if (ix < 0) begin
                e3 = 7'h3f; e2 = 7'h3f; e1 = 7'h3f; e0 = 7'h3f;
            end else begin
                e3 = seg_t[ix]; e2 = 7'h7f; e1 = seg_t[(m_rem / 10) % 10]; e0 = seg_t[m_rem % 10];
            end
            chk("remaining", int'(remaining), m_rem);
            chk("stage_done", int'(stage_done), m_done);
            chk("HEX3", int'(hex3), e3);
            chk("HEX2", int'(hex2), e2);
            chk("HEX1", int'(hex1), e1);
            chk("HEX0", int'(hex0), e0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct { logic [9:0] st; logic [1:0] sp; int exp; } spd_t;
    spd_t spd_tab [5] = '{
        '{BRUSH, 2'b01, 3}, '{BLAST, 2'b01, 1}, '{BRUSH, 2'b10, 9},
        '{ENDST, 2'b10, 3}, '{DRY,   2'b11, 5}
    };

    initial begin
        int guard;
        rst_n = 1'b0; state = IDLE; speed = 2'b00; hold = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("reset_rem", int'(remaining), 0);
        chk("reset_HEX3", int'(hex3), 7'h40);
        chk("reset_HEX2", int'(hex2), 7'h7f);

        // Basic Soak countdown
        state = SOAK;
        step(2);
        chk("soak_load", int'(remaining), 5);
        chk("soak_HEX3", int'(hex3), 7'h79);
        step(19);
        chk("soak_last_sec", int'(remaining), 1);
        chk("soak_no_early_done", int'(stage_done), 0);
        step(1);
        chk("soak_done_pulse", int'(stage_done), 1);
        chk("soak_zero", int'(remaining), 0);
        step(1);
        chk("soak_done_single", int'(stage_done), 0);
        step(10);
        chk("soak_stays_zero", int'(remaining), 0);

        // Speed table
        foreach (spd_tab[k]) begin
            state = IDLE; step(3);
            speed = spd_tab[k].sp; state = spd_tab[k].st;
            step(2);
            chk("speed_table", int'(remaining), spd_tab[k].exp);
        end
        speed = 2'b00;

        // Mid-stage speed change does not alter the running count
        state = IDLE; step(3);
        state = SOAK; step(2);
        speed = 2'b01;
        step(4);
        chk("midstage_speed", int'(remaining), 4);
        speed = 2'b00;

        // Hold at remaining=3
        guard = 0;
        while (m_rem != 3 && guard < 40) begin step(1); guard++; end
        chk("hold_reach3_timeout", guard < 40, 1);
        hold = 1'b1;
        step(2);
        chk("hold_blank", int'(hex0), 7'h7f);
        step(18);
        chk("hold_frozen", int'(remaining), 3);
        hold = 1'b0;
        guard = 0;
        while (remaining == 8'd3 && guard < 20) begin step(1); guard++; end
        chk("hold_resume", int'(remaining), 2);

        // Stage change coincident with a tick, while on the last second
        state = IDLE; step(3);
        state = SOAK; step(2);
        guard = 0;
        while (!(m_rem == 1 && m_pre == TD - 2) && guard < 60) begin step(1); guard++; end
        chk("collide_setup_timeout", guard < 60, 1);
        state = SOAP;
        step(2);
        chk("collide_reload", int'(remaining), 4);
        chk("collide_no_done", int'(stage_done), 0);
        step(1);
        chk("collide_no_late_done", int'(stage_done), 0);

        // Invalid stage vectors
        state = 10'b0000000000;
        step(3);
        chk("invalid0_HEX3", int'(hex3), 7'h3f);
        chk("invalid0_rem", int'(remaining), 0);
        step(40);
        state = 10'b0110000000;
        step(42);
        chk("invalid2_HEX0", int'(hex0), 7'h3f);

        // Reset asserted mid-count
        state = IDLE; step(3);
        state = SOAK; step(8);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rem", int'(remaining), 0);
        chk("async_rst_done", int'(stage_done), 0);
        chk("async_rst_HEX3", int'(hex3), 7'h40);
        chk("async_rst_HEX1", int'(hex1), 7'h40);
        chk("async_rst_HEX0", int'(hex0), 7'h40);
        state = IDLE;
        step(2);
        rst_n = 1'b1;
        step(2);

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_done == 1 && $urandom_range(0, 1) == 1) begin
                state = (state == ENDST) ? IDLE : (state >> 1);
            end else if (r < 3) begin
                state = 10'b1 << $urandom_range(0, 9);
            end else if (r == 3) begin
                state = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 99) < 3) hold = ~hold;
            if ($urandom_range(0, 99) < 5) speed = 2'($urandom_range(0, 3));
            step(1);
        end
        hold = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
